// File: rtl/ctrl_pipeline_if.sv
// Control-bundle interface between the ID-stage decoder and the pipeline control block.
// Signal prefixes are from the pipeline's point of view: i_ = into ctrl_pipeline, o_ = out of it.
interface ctrl_pipeline_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic             i_id_valid;
    logic             i_id_regdst;
    logic             i_id_branch;
    logic             i_id_memread;
    logic             i_id_memtoreg;
    logic             i_id_memwrite;
    logic             i_id_alusrc;
    logic             i_id_regwrite;
    logic [1:0]       i_id_aluop;
    logic [RA_W-1:0]  i_id_rs;
    logic [RA_W-1:0]  i_id_rt;
    logic [RA_W-1:0]  i_id_rd;
    logic             i_ex_zero;

    logic             o_ex_regdst;
    logic             o_ex_alusrc;
    logic [1:0]       o_ex_aluop;
    logic [RA_W-1:0]  o_ex_rt;
    logic             o_mem_branch;
    logic             o_mem_memread;
    logic             o_mem_memwrite;
    logic             o_wb_memtoreg;
    logic             o_wb_regwrite;
    logic [RA_W-1:0]  o_wb_dst;
    logic             o_stall;
    logic             o_flush;
    logic             o_pc_src;
    logic [CNT_W-1:0] o_retired_cnt;

    modport master (
        output i_id_valid, i_id_regdst, i_id_branch, i_id_memread, i_id_memtoreg,
               i_id_memwrite, i_id_alusrc, i_id_regwrite, i_id_aluop,
               i_id_rs, i_id_rt, i_id_rd, i_ex_zero,
        input  o_ex_regdst, o_ex_alusrc, o_ex_aluop, o_ex_rt,
               o_mem_branch, o_mem_memread, o_mem_memwrite,
               o_wb_memtoreg, o_wb_regwrite, o_wb_dst,
               o_stall, o_flush, o_pc_src, o_retired_cnt
    );

    modport slave (
        input  i_id_valid, i_id_regdst, i_id_branch, i_id_memread, i_id_memtoreg,
               i_id_memwrite, i_id_alusrc, i_id_regwrite, i_id_aluop,
               i_id_rs, i_id_rt, i_id_rd, i_ex_zero,
        output o_ex_regdst, o_ex_alusrc, o_ex_aluop, o_ex_rt,
               o_mem_branch, o_mem_memread, o_mem_memwrite,
               o_wb_memtoreg, o_wb_regwrite, o_wb_dst,
               o_stall, o_flush, o_pc_src, o_retired_cnt
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// Carries decoder control bits through ID/EX, EX/MEM and MEM/WB, detects load-use stalls
// and taken-branch flushes, and counts instructions retiring from WB.
module ctrl_pipeline #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_pipeline_if.slave    bus
);

    typedef struct packed {
        logic            valid;
        logic            regdst;
        logic [1:0]      aluop;
        logic            alusrc;
        logic            branch;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            regwrite;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] rd;
    } ex_stage_t;

    typedef struct packed {
        logic            valid;
        logic            branch;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            regwrite;
        logic            zero;
        logic [RA_W-1:0] dst;
    } mem_stage_t;

    typedef struct packed {
        logic            valid;
        logic            memtoreg;
        logic            regwrite;
        logic [RA_W-1:0] dst;
    } wb_stage_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_stage_t        r_ex;
    mem_stage_t       r_mem;
    wb_stage_t        r_wb;
    logic [CNT_W-1:0] r_retired_cnt;

    ex_stage_t        w_id_next;
    mem_stage_t       w_mem_next;
    wb_stage_t        w_wb_next;
    logic             w_flush;
    logic             w_load_use;
    logic             w_stall;

    // RegDst and MemtoReg are don't-cares for sw/beq; masking them with RegWrite here
    // keeps an undriven decoder bit from ever propagating down the pipe.
    always_comb begin
        w_id_next = '0;
        if (bus.i_id_valid) begin
            w_id_next.valid    = 1'b1;
            w_id_next.regdst   = bus.i_id_regwrite & bus.i_id_regdst;
            w_id_next.aluop    = bus.i_id_aluop;
            w_id_next.alusrc   = bus.i_id_alusrc;
            w_id_next.branch   = bus.i_id_branch;
            w_id_next.memread  = bus.i_id_memread;
            w_id_next.memwrite = bus.i_id_memwrite;
            w_id_next.memtoreg = bus.i_id_regwrite & bus.i_id_memtoreg;
            w_id_next.regwrite = bus.i_id_regwrite;
            w_id_next.rt       = bus.i_id_rt;
            w_id_next.rd       = bus.i_id_rd;
        end
    end

    always_comb begin
        w_mem_next = '0;
        if (r_ex.valid) begin
            w_mem_next.valid    = 1'b1;
            w_mem_next.branch   = r_ex.branch;
            w_mem_next.memread  = r_ex.memread;
            w_mem_next.memwrite = r_ex.memwrite;
            w_mem_next.memtoreg = r_ex.memtoreg;
            w_mem_next.regwrite = r_ex.regwrite;
            w_mem_next.zero     = bus.i_ex_zero;
            w_mem_next.dst      = r_ex.regdst ? r_ex.rd : r_ex.rt;
        end
    end

    always_comb begin
        w_wb_next = '0;
        if (r_mem.valid) begin
            w_wb_next.valid    = 1'b1;
            w_wb_next.memtoreg = r_mem.memtoreg;
            w_wb_next.regwrite = r_mem.regwrite;
            w_wb_next.dst      = r_mem.dst;
        end
    end

    // A taken branch squashes the younger instructions, so it overrides any stall.
    always_comb begin
        w_flush    = r_mem.valid & r_mem.branch & r_mem.zero;
        w_load_use = r_ex.valid & r_ex.memread & bus.i_id_valid &
                     ((r_ex.rt == bus.i_id_rs) | (r_ex.rt == bus.i_id_rt));
        w_stall    = w_load_use & ~w_flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_retired_cnt <= '0;
        end else begin
            r_ex  <= (w_flush | w_stall) ? ex_stage_t'('0) : w_id_next;
            r_mem <= w_flush ? mem_stage_t'('0) : w_mem_next;
            r_wb  <= w_wb_next;
            if (r_wb.valid) begin
                r_retired_cnt <= r_retired_cnt + CNT_ONE;
            end
        end
    end

    assign bus.o_ex_regdst    = r_ex.valid & r_ex.regdst;
    assign bus.o_ex_alusrc    = r_ex.valid & r_ex.alusrc;
    assign bus.o_ex_aluop     = r_ex.valid ? r_ex.aluop : 2'b00;
    assign bus.o_ex_rt        = r_ex.valid ? r_ex.rt : '0;
    assign bus.o_mem_branch   = r_mem.valid & r_mem.branch;
    assign bus.o_mem_memread  = r_mem.valid & r_mem.memread;
    assign bus.o_mem_memwrite = r_mem.valid & r_mem.memwrite;
    assign bus.o_wb_memtoreg  = r_wb.valid & r_wb.memtoreg;
    assign bus.o_wb_regwrite  = r_wb.valid & r_wb.regwrite;
    assign bus.o_wb_dst       = r_wb.valid ? r_wb.dst : '0;
    assign bus.o_stall        = w_stall;
    assign bus.o_flush        = w_flush;
    assign bus.o_pc_src       = w_flush;
    assign bus.o_retired_cnt  = r_retired_cnt;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: a full-width instance plus a 3-bit-counter instance
// sharing the same stimulus so counter wrap can be reached quickly.
module tb_ctrl_pipeline;

    localparam int RA_W    = 5;
    localparam int CNT_W   = 32;
    localparam int CNT_W_S = 3;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;

    ctrl_pipeline_if #(.RA_W(RA_W), .CNT_W(CNT_W))   mIf ();
    ctrl_pipeline_if #(.RA_W(RA_W), .CNT_W(CNT_W_S)) sIf ();

    ctrl_pipeline #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mIf.slave)
    );

    ctrl_pipeline #(.RA_W(RA_W), .CNT_W(CNT_W_S)) dutSmall (
        .clk (clk),
        .rst (rst),
        .bus (sIf.slave)
    );

    assign sIf.i_id_valid    = mIf.i_id_valid;
    assign sIf.i_id_regdst   = mIf.i_id_regdst;
    assign sIf.i_id_branch   = mIf.i_id_branch;
    assign sIf.i_id_memread  = mIf.i_id_memread;
    assign sIf.i_id_memtoreg = mIf.i_id_memtoreg;
    assign sIf.i_id_memwrite = mIf.i_id_memwrite;
    assign sIf.i_id_alusrc   = mIf.i_id_alusrc;
    assign sIf.i_id_regwrite = mIf.i_id_regwrite;
    assign sIf.i_id_aluop    = mIf.i_id_aluop;
    assign sIf.i_id_rs       = mIf.i_id_rs;
    assign sIf.i_id_rt       = mIf.i_id_rt;
    assign sIf.i_id_rd       = mIf.i_id_rd;
    assign sIf.i_ex_zero     = mIf.i_ex_zero;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic regdst, input logic branch,
                                 input logic memread, input logic memtoreg, input logic memwrite,
                                 input logic alusrc, input logic regwrite, input logic [1:0] aluop,
                                 input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                                 input logic [RA_W-1:0] rd);
        mIf.i_id_valid    = valid;
        mIf.i_id_regdst   = regdst;
        mIf.i_id_branch   = branch;
        mIf.i_id_memread  = memread;
        mIf.i_id_memtoreg = memtoreg;
        mIf.i_id_memwrite = memwrite;
        mIf.i_id_alusrc   = alusrc;
        mIf.i_id_regwrite = regwrite;
        mIf.i_id_aluop    = aluop;
        mIf.i_id_rs       = rs;
        mIf.i_id_rt       = rt;
        mIf.i_id_rd       = rd;
    endtask

    task automatic driveNop();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic driveRtype(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                              input logic [RA_W-1:0] rd);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, rs, rt, rd);
    endtask

    task automatic driveLw(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, rs, rt, 5'd0);
    endtask

    task automatic driveSw(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt);
        applyStimulus(1'b1, 1'bx, 1'b0, 1'b0, 1'bx, 1'b1, 1'b1, 1'b0, 2'b00, rs, rt, 5'd0);
    endtask

    task automatic driveBeq(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt);
        applyStimulus(1'b1, 1'bx, 1'b1, 1'b0, 1'bx, 1'b0, 1'b0, 1'b0, 2'b01, rs, rt, 5'd0);
    endtask

    // Advance one clock; outputs are sampled 2 time units after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        assertCount   = 0;
        failCount     = 0;
        rst           = 1'b1;
        mIf.i_ex_zero = 1'b0;
        driveNop();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ex_aluop", {62'd0, mIf.o_ex_aluop}, 64'd0);
        checkOutput("rst_wb_regwrite", {63'd0, mIf.o_wb_regwrite}, 64'd0);
        checkOutput("rst_stall", {63'd0, mIf.o_stall}, 64'd0);
        checkOutput("rst_flush", {63'd0, mIf.o_flush}, 64'd0);
        checkOutput("rst_retired", {32'd0, mIf.o_retired_cnt}, 64'd0);
        #1;
        rst = 1'b0;

        // R-type through all stages
        driveRtype(5'd1, 5'd2, 5'd5);
        cycle();
        checkOutput("rt_ex_aluop", {62'd0, mIf.o_ex_aluop}, 64'd2);
        checkOutput("rt_ex_regdst", {63'd0, mIf.o_ex_regdst}, 64'd1);
        driveNop();
        cycle();
        checkOutput("rt_mem_memread", {63'd0, mIf.o_mem_memread}, 64'd0);
        cycle();
        checkOutput("rt_wb_regwrite", {63'd0, mIf.o_wb_regwrite}, 64'd1);
        checkOutput("rt_wb_dst", {59'd0, mIf.o_wb_dst}, 64'd5);
        checkOutput("rt_retired_pre", {32'd0, mIf.o_retired_cnt}, 64'd0);
        cycle();
        checkOutput("rt_retired", {32'd0, mIf.o_retired_cnt}, 64'd1);

        // Load-use: lw r8 then add using r8
        driveLw(5'd0, 5'd8);
        cycle();
        driveRtype(5'd8, 5'd3, 5'd9);
        #1;
        checkOutput("lu_stall", {63'd0, mIf.o_stall}, 64'd1);
        checkOutput("lu_flush", {63'd0, mIf.o_flush}, 64'd0);
        cycle();
        checkOutput("lu_bubble_aluop", {62'd0, mIf.o_ex_aluop}, 64'd0);
        checkOutput("lu_bubble_regdst", {63'd0, mIf.o_ex_regdst}, 64'd0);
        checkOutput("lu_mem_memread", {63'd0, mIf.o_mem_memread}, 64'd1);
        checkOutput("lu_stall_released", {63'd0, mIf.o_stall}, 64'd0);
        cycle();
        checkOutput("lu_add_ex_aluop", {62'd0, mIf.o_ex_aluop}, 64'd2);
        checkOutput("lu_lw_wb_memtoreg", {63'd0, mIf.o_wb_memtoreg}, 64'd1);
        checkOutput("lu_lw_wb_dst", {59'd0, mIf.o_wb_dst}, 64'd8);
        driveNop();
        cycle();
        checkOutput("lu_wb_bubble", {63'd0, mIf.o_wb_regwrite}, 64'd0);
        cycle();
        checkOutput("lu_add_wb_regwrite", {63'd0, mIf.o_wb_regwrite}, 64'd1);
        checkOutput("lu_add_wb_dst", {59'd0, mIf.o_wb_dst}, 64'd9);
        checkOutput("lu_retired", {32'd0, mIf.o_retired_cnt}, 64'd2);
        cycle();
        checkOutput("lu_retired_post", {32'd0, mIf.o_retired_cnt}, 64'd3);

        // Taken beq flushes the two younger instructions
        driveBeq(5'd1, 5'd2);
        cycle();
        mIf.i_ex_zero = 1'b1;
        driveRtype(5'd1, 5'd2, 5'd7);
        cycle();
        mIf.i_ex_zero = 1'b0;
        driveRtype(5'd1, 5'd2, 5'd10);
        #1;
        checkOutput("br_flush", {63'd0, mIf.o_flush}, 64'd1);
        checkOutput("br_pc_src", {63'd0, mIf.o_pc_src}, 64'd1);
        checkOutput("br_mem_branch", {63'd0, mIf.o_mem_branch}, 64'd1);
        cycle();
        checkOutput("br_ex_squash", {62'd0, mIf.o_ex_aluop}, 64'd0);
        checkOutput("br_mem_squash", {63'd0, mIf.o_mem_branch}, 64'd0);
        checkOutput("br_wb_regwrite", {63'd0, mIf.o_wb_regwrite}, 64'd0);
        checkOutput("br_wb_memtoreg", {63'd0, mIf.o_wb_memtoreg}, 64'd0);
        checkOutput("br_flush_clear", {63'd0, mIf.o_flush}, 64'd0);
        driveNop();
        cycle();
        checkOutput("br_retired", {32'd0, mIf.o_retired_cnt}, 64'd4);

        // Load-use hazard coinciding with taken branch: flush wins
        driveBeq(5'd3, 5'd3);
        cycle();
        mIf.i_ex_zero = 1'b1;
        driveLw(5'd0, 5'd4);
        cycle();
        mIf.i_ex_zero = 1'b0;
        driveRtype(5'd4, 5'd0, 5'd11);
        #1;
        checkOutput("pri_flush", {63'd0, mIf.o_flush}, 64'd1);
        checkOutput("pri_stall", {63'd0, mIf.o_stall}, 64'd0);
        checkOutput("pri_ex_rt", {59'd0, mIf.o_ex_rt}, 64'd4);
        cycle();
        checkOutput("pri_mem_memread", {63'd0, mIf.o_mem_memread}, 64'd0);
        checkOutput("pri_ex_rt_squash", {59'd0, mIf.o_ex_rt}, 64'd0);
        driveNop();
        cycle();
        checkOutput("pri_retired", {32'd0, mIf.o_retired_cnt}, 64'd5);

        // sw with undriven RegDst/MemtoReg
        driveSw(5'd1, 5'd6);
        cycle();
        checkOutput("sw_ex_regdst", {63'd0, mIf.o_ex_regdst}, 64'd0);
        checkOutput("sw_ex_alusrc", {63'd0, mIf.o_ex_alusrc}, 64'd1);
        driveNop();
        cycle();
        checkOutput("sw_mem_memwrite", {63'd0, mIf.o_mem_memwrite}, 64'd1);
        cycle();
        checkOutput("sw_wb_regwrite", {63'd0, mIf.o_wb_regwrite}, 64'd0);
        checkOutput("sw_wb_memtoreg", {63'd0, mIf.o_wb_memtoreg}, 64'd0);
        checkOutput("sw_wb_dst", {59'd0, mIf.o_wb_dst}, 64'd6);
        cycle();
        checkOutput("sw_retired", {32'd0, mIf.o_retired_cnt}, 64'd6);

        // Asynchronous reset with a full pipe
        driveRtype(5'd1, 5'd2, 5'd3);
        cycle();
        driveRtype(5'd1, 5'd2, 5'd4);
        cycle();
        driveRtype(5'd1, 5'd2, 5'd5);
        cycle();
        checkOutput("mr_wb_dst_pre", {59'd0, mIf.o_wb_dst}, 64'd3);
        rst = 1'b1;
        #1;
        checkOutput("mr_wb_regwrite", {63'd0, mIf.o_wb_regwrite}, 64'd0);
        checkOutput("mr_wb_dst", {59'd0, mIf.o_wb_dst}, 64'd0);
        checkOutput("mr_ex_aluop", {62'd0, mIf.o_ex_aluop}, 64'd0);
        checkOutput("mr_mem_memwrite", {63'd0, mIf.o_mem_memwrite}, 64'd0);
        checkOutput("mr_retired", {32'd0, mIf.o_retired_cnt}, 64'd0);
        driveNop();
        cycle();
        rst = 1'b0;
        cycle();
        checkOutput("mr_retired_post", {32'd0, mIf.o_retired_cnt}, 64'd0);
        checkOutput("mr_small_retired", {61'd0, sIf.o_retired_cnt}, 64'd0);

        // Retirement count and wrap of the 3-bit counter
        for (int i = 0; i < 7; i++) begin
            driveRtype(5'd1, 5'd2, 5'(i + 1));
            cycle();
        end
        driveNop();
        repeat (4) cycle();
        checkOutput("cnt_7", {32'd0, mIf.o_retired_cnt}, 64'd7);
        checkOutput("cnt_small_max", {61'd0, sIf.o_retired_cnt}, 64'd7);
        driveRtype(5'd1, 5'd2, 5'd20);
        cycle();
        driveNop();
        repeat (4) cycle();
        checkOutput("cnt_8", {32'd0, mIf.o_retired_cnt}, 64'd8);
        checkOutput("cnt_small_wrap", {61'd0, sIf.o_retired_cnt}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            driveRtype(5'd1, 5'd2, 5'(i + 21));
            cycle();
        end
        driveNop();
        repeat (4) cycle();
        checkOutput("cnt_10", {32'd0, mIf.o_retired_cnt}, 64'd10);
        checkOutput("cnt_small_2", {61'd0, sIf.o_retired_cnt}, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
